// File: rtl/seq_mult16.sv
// seq_mult16: iterative shift-add unsigned multiplier for the execute stage.
// One partial product per cycle for WIDTH cycles, then a one-cycle Done pulse.
// Result holds the low WIDTH bits of A*B until the next completion.
//
// Handshake: Start is a request sampled on a rising clk edge. It is accepted
// only in IDLE or DONE. Busy is high while the operation iterates, and Start
// is ignored in that state. Done pulses for one cycle when the Result (and
// ResultHi) registers take the new product.
//
// Build option: define SEQ_MULT16_HI_EN to add ResultHi, which holds the
// upper WIDTH bits of the full product. Without it, the accumulator is only
// WIDTH bits wide.
module seq_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
`ifdef SEQ_MULT16_HI_EN
    ,
    output logic [WIDTH-1:0] ResultHi
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef SEQ_MULT16_HI_EN
    localparam int ACCW = 2 * WIDTH;
`else
    localparam int ACCW = WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // state is the FSM debug view; bind checkers to it directly.
    state_t state;
    state_t state_next;

    logic             load;
    logic             step;
    logic             finish;
    logic             last;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [ACCW-1:0]  acc;
    logic [ACCW-1:0]  addend;
    logic [ACCW-1:0]  acc_sum;

    // The last iteration happens when the counter reaches WIDTH-1.
    assign last    = (cnt == CW'(WIDTH - 1));
    // Zero-extend the multiplicand and shift it into place for this iteration.
    assign addend  = ACCW'(mcand) << cnt;
    // Add the partial product only when the current multiplier bit is set.
    assign acc_sum = mplier[0] ? (acc + addend) : acc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and control strobes. DONE may accept a new request
    // directly, so back-to-back operations take WIDTH+1 cycles each.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, accumulation, multiplier shift and iteration count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_sum;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // Output registers. They take the final sum on the edge that raises Done
    // and hold it through IDLE and RUN so the writeback mux input is stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result   <= '0;
`ifdef SEQ_MULT16_HI_EN
            ResultHi <= '0;
`endif
        end else if (finish) begin
            Result   <= acc_sum[WIDTH-1:0];
`ifdef SEQ_MULT16_HI_EN
            ResultHi <= acc_sum[ACCW-1:WIDTH];
`endif
        end
    end

endmodule

// File: tb/tb_seq_mult16.sv
// tb_seq_mult16: directed checks of seq_mult16 using hand-computed products.
// All inputs are driven, and all outputs sampled, 1 ns after a rising clk edge.
// Define SEQ_MULT16_HI_EN to also check ResultHi.
module tb_seq_mult16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
`ifdef SEQ_MULT16_HI_EN
    logic [15:0] result_hi;
`endif

    int checks;
    int errors;
    int lat;
    int busy_cnt;
    int done_cnt;
    int busy_seen;

    seq_mult16 #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .Start  (start),
        .A      (a),
        .B      (b),
        .Busy   (busy),
        .Done   (done),
        .Result (result)
`ifdef SEQ_MULT16_HI_EN
        ,
        .ResultHi (result_hi)
`endif
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value, count it, and report it if it differs.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 ns after the rising edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge. On return the bench is in cycle T+1.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        step_clk();
        start = 1'b0;
        a     = 16'hxxxx;
        b     = 16'hxxxx;
    endtask

    // Wait, with a bound, until Done is high. Report the cycle number, measured
    // relative to the Start edge, and the number of cycles Busy was high.
    task automatic wait_done(input int first_cycle, output int cyc, output int nbusy);
        cyc   = first_cycle;
        nbusy = (first_cycle > 1) ? first_cycle - 1 : 0;
        while (!done && cyc < 60) begin
            if (busy) nbusy++;
            step_clk();
            cyc++;
        end
    endtask

    // Watch n cycles. Count Done pulses and cycles with Busy high.
    task automatic watch_idle(input int n, output int ndone, output int nbusy);
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < n; i++) begin
            if (done) ndone++;
            if (busy) nbusy++;
            step_clk();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = 16'h0000;
        b      = 16'h0000;

        // Reset state.
        step_clk();
        step_clk();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'h0);
`ifdef SEQ_MULT16_HI_EN
        check("reset_result_hi", 32'(result_hi), 32'h0);
`endif
        rst = 1'b0;
        step_clk();

        // 1: 3 * 5. Busy is high for 16 cycles, and Done is high in cycle T+17.
        start_op(16'h0003, 16'h0005);
        check("t1_busy_first", 32'(busy), 32'd1);
        wait_done(1, lat, busy_cnt);
        check("t1_latency", 32'(lat), 32'd17);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd16);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_in_done", 32'(busy), 32'd0);
        check("t1_result", 32'(result), 32'h000F);
`ifdef SEQ_MULT16_HI_EN
        check("t1_result_hi", 32'(result_hi), 32'h0000);
`endif
        step_clk();
        check("t1_done_pulse_width", 32'(done), 32'd0);
        check("t1_result_held_idle", 32'(result), 32'h000F);

        // 2: 0xFFFF * 0xFFFF = 0xFFFE0001. Result keeps its old value during RUN.
        start_op(16'hFFFF, 16'hFFFF);
        check("t2_result_held_run", 32'(result), 32'h000F);
        wait_done(1, lat, busy_cnt);
        check("t2_latency", 32'(lat), 32'd17);
        check("t2_result", 32'(result), 32'h0001);
`ifdef SEQ_MULT16_HI_EN
        check("t2_result_hi", 32'(result_hi), 32'hFFFE);
`endif
        step_clk();

        // 3: 0x1234 * 0x0010. A Start pulse during RUN is ignored.
        start_op(16'h1234, 16'h0010);
        step_clk();
        step_clk();
        step_clk();
        start = 1'b1;
        a     = 16'h0002;
        b     = 16'h0002;
        step_clk();
        start = 1'b0;
        wait_done(5, lat, busy_cnt);
        check("t3_latency", 32'(lat), 32'd17);
        check("t3_result", 32'(result), 32'h2340);
`ifdef SEQ_MULT16_HI_EN
        check("t3_result_hi", 32'(result_hi), 32'h0001);
`endif
        step_clk();
        watch_idle(30, done_cnt, busy_seen);
        check("t3_extra_done", 32'(done_cnt), 32'd0);
        check("t3_extra_busy", 32'(busy_seen), 32'd0);

        // 4: Reset in cycle T+8 abandons the operation.
        start_op(16'h00FF, 16'h0101);
        for (int i = 0; i < 7; i++) step_clk();
        check("t4_busy_before_rst", 32'(busy), 32'd1);
        check("t4_result_before_rst", 32'(result), 32'h2340);
        rst = 1'b1;
        #1;
        check("t4_busy_in_rst", 32'(busy), 32'd0);
        check("t4_result_in_rst", 32'(result), 32'h0000);
`ifdef SEQ_MULT16_HI_EN
        check("t4_result_hi_in_rst", 32'(result_hi), 32'h0000);
`endif
        step_clk();
        rst = 1'b0;
        watch_idle(30, done_cnt, busy_seen);
        check("t4_no_done", 32'(done_cnt), 32'd0);
        check("t4_no_busy", 32'(busy_seen), 32'd0);
        check("t4_result_after", 32'(result), 32'h0000);

        // 5: 7 * 6, then a second operation accepted in the Done cycle.
        start_op(16'h0007, 16'h0006);
        wait_done(1, lat, busy_cnt);
        check("t5a_latency", 32'(lat), 32'd17);
        check("t5a_result", 32'(result), 32'h002A);
`ifdef SEQ_MULT16_HI_EN
        check("t5a_result_hi", 32'(result_hi), 32'h0000);
`endif
        start_op(16'h0000, 16'h1234);
        check("t5b_busy_after_done", 32'(busy), 32'd1);
        check("t5b_done_cleared", 32'(done), 32'd0);
        check("t5b_result_held", 32'(result), 32'h002A);
        wait_done(1, lat, busy_cnt);
        check("t5b_latency", 32'(lat), 32'd17);
        check("t5b_busy_cycles", 32'(busy_cnt), 32'd16);
        check("t5b_result", 32'(result), 32'h0000);
        step_clk();

        // 6: 0x8000 * 2 = 0x10000.
        start_op(16'h8000, 16'h0002);
        wait_done(1, lat, busy_cnt);
        check("t6_latency", 32'(lat), 32'd17);
        check("t6_result", 32'(result), 32'h0000);
`ifdef SEQ_MULT16_HI_EN
        check("t6_result_hi", 32'(result_hi), 32'h0001);
`endif
        step_clk();

        // Extra vector: 0x00FF * 0x0101 = 0xFFFF, with every bit of the low half set.
        start_op(16'h00FF, 16'h0101);
        wait_done(1, lat, busy_cnt);
        check("t7_result", 32'(result), 32'hFFFF);
`ifdef SEQ_MULT16_HI_EN
        check("t7_result_hi", 32'(result_hi), 32'h0000);
`endif
        step_clk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
